// File: rtl/pcie_phy_pkg.sv
// Shared definitions for the PCIe PHY transmit lane: symbol width,
// K28.5 comma code groups and the 10-bit line-code symbol type.
package pcie_phy_pkg;

    localparam int SYMBOL_W = 10;

    // K28.5 comma, running disparity negative / positive (bit 0 = code bit 'a').
    localparam logic [9:0] K28_5_RDN = 10'h17C;
    localparam logic [9:0] K28_5_RDP = 10'h283;

    typedef logic [SYMBOL_W-1:0] symbol_t;

endpackage : pcie_phy_pkg

// File: rtl/tx_serializer_10b.sv
// 10-bit symbol to one-bit-per-clock serializer for a PCIe TX lane.
// One-entry hold buffer behind a valid/ready handshake; a fill symbol is
// inserted at any symbol boundary with nothing to send, so the symbol
// period is always exactly 10 clocks.
module tx_serializer_10b
    import pcie_phy_pkg::*;
#(
    parameter int      SYMBOL_W    = 10,
    parameter symbol_t IDLE_SYMBOL = K28_5_RDN,
    parameter bit      LSB_FIRST   = 1'b1
) (
    input  logic    clk,
    input  logic    reset,
    input  symbol_t symbol_i,
    input  logic    symbol_valid_i,
    output logic    symbol_ready_o,
    output logic    serial_o,
    output logic    symbol_start_o,
    output logic    idle_fill_o
);

    localparam logic [3:0] LAST_BIT = 4'd9;

    // The datapath is hard-wired for 10-bit code groups.
    if (SYMBOL_W != 10) begin : g_symbol_w_check
        $error("tx_serializer_10b: SYMBOL_W must be 10");
    end

    symbol_t    shift_q, shift_d;
    symbol_t    hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;
    logic       idle_q, idle_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;

    logic       boundary_s;
    logic       xfer_s;
    logic       ready_s;

    // Handshake and boundary decode; ready depends on registered state only.
    always_comb begin
        boundary_s = (bit_cnt_q == LAST_BIT);
        ready_s    = !hold_vld_q || boundary_s;
        xfer_s     = symbol_valid_i && ready_s;
    end

    // Next-state: bit counter, boundary load priority and hold buffer fill.
    always_comb begin
        shift_d    = shift_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        idle_d     = idle_q;
        bit_cnt_d  = bit_cnt_q;

        if (boundary_s) begin
            bit_cnt_d = 4'd0;
            if (hold_vld_q) begin
                // Held symbol goes out; a concurrent transfer refills the hold.
                shift_d = hold_q;
                idle_d  = 1'b0;
                if (xfer_s) begin
                    hold_d     = symbol_i;
                    hold_vld_d = 1'b1;
                end else begin
                    hold_vld_d = 1'b0;
                end
            end else if (xfer_s) begin
                // Bypass: symbol arriving right at the boundary skips the hold.
                shift_d = symbol_i;
                idle_d  = 1'b0;
            end else begin
                shift_d = IDLE_SYMBOL;
                idle_d  = 1'b1;
            end
        end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (xfer_s) begin
                hold_d     = symbol_i;
                hold_vld_d = 1'b1;
            end else begin
                hold_vld_d = hold_vld_q;
            end
        end
    end

    // State registers with synchronous reset to a fill symbol at bit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= IDLE_SYMBOL;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            idle_q     <= 1'b1;
            bit_cnt_q  <= 4'd0;
        end else begin
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            idle_q     <= idle_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    // Output decode: bit select in the configured order plus framing flags.
    always_comb begin
        if (LSB_FIRST) begin
            serial_o = shift_q[bit_cnt_q];
        end else begin
            serial_o = shift_q[LAST_BIT - bit_cnt_q];
        end
        symbol_start_o = (bit_cnt_q == 4'd0);
        idle_fill_o    = idle_q;
        symbol_ready_o = ready_s;
    end

endmodule : tx_serializer_10b

// File: tb/tb_tx_serializer_10b.sv
// Scoreboard bench for tx_serializer_10b: stimulus pushes accepted symbols
// into a queue, a monitor reassembles each 10-bit period from serial_o and
// checks it against the queue (data) or the K28.5 constant (fill).
module tb_tx_serializer_10b;
    import pcie_phy_pkg::*;

    localparam logic [9:0] IDLE = 10'h17C;

    logic    clk = 1'b0;
    logic    reset;
    symbol_t symbol_i;
    logic    symbol_valid_i, symbol_ready_o, serial_o, symbol_start_o, idle_fill_o;
    symbol_t m_symbol_i;
    logic    m_valid_i, m_ready_o, m_serial_o, m_start_o, m_idle_o;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int tb_cnt    = 0;
    int cyc       = 0;
    int data_cnt  = 0;
    int idle_cnt  = 0;
    logic [9:0] exp_q[$];

    tx_serializer_10b #(.LSB_FIRST(1'b1)) u_dut (
        .clk(clk), .reset(reset), .symbol_i(symbol_i), .symbol_valid_i(symbol_valid_i),
        .symbol_ready_o(symbol_ready_o), .serial_o(serial_o),
        .symbol_start_o(symbol_start_o), .idle_fill_o(idle_fill_o)
    );

    tx_serializer_10b #(.LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .reset(reset), .symbol_i(m_symbol_i), .symbol_valid_i(m_valid_i),
        .symbol_ready_o(m_ready_o), .serial_o(m_serial_o),
        .symbol_start_o(m_start_o), .idle_fill_o(m_idle_o)
    );

    always #5 clk = ~clk;

    // Reference bit counter and free-running cycle count.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) tb_cnt <= 0;
        else       tb_cnt <= (tb_cnt == 9) ? 0 : tb_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int n);
        int k = 0;
        do begin
            step();
            k++;
        end while (tb_cnt != n && k < 20);
    endtask

    task automatic wait_data(input int n);
        int k = 0;
        while (data_cnt < n && k < 60) begin
            step();
            k++;
        end
        check("data_wait", 32'(data_cnt >= n), 32'd1);
    endtask

    // Offer a symbol, hold it until ready, record the accept cycle.
    task automatic send(input symbol_t s, output int acc_cyc);
        int k = 0;
        symbol_i       = s;
        symbol_valid_i = 1'b1;
        while (!symbol_ready_o && k < 40) begin
            step();
            k++;
        end
        check("accept_timeout", 32'(k < 40), 32'd1);
        acc_cyc = cyc;
        exp_q.push_back(s);
        step();
        symbol_valid_i = 1'b0;
    endtask

    // Monitor: reassemble each symbol period and score it.
    initial begin
        logic [9:0] bits;
        int pos;
        logic started, sym_idle, idle_ok, nonempty;
        started = 1'b0;
        pos = 0;
        bits = 10'd0;
        sym_idle = 1'b0;
        idle_ok = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                started = 1'b0;
                pos = 0;
            end else begin
                check("symbol_start", 32'(symbol_start_o), 32'(tb_cnt == 0));
                if (symbol_start_o) begin
                    started  = 1'b1;
                    pos      = 0;
                    bits     = 10'd0;
                    sym_idle = idle_fill_o;
                    idle_ok  = 1'b1;
                end
                if (started) begin
                    bits[pos] = serial_o;
                    if (idle_fill_o !== sym_idle) idle_ok = 1'b0;
                    pos++;
                    if (pos == 10) begin
                        check("idle_flag_stable", 32'(idle_ok), 32'd1);
                        if (sym_idle) begin
                            check("idle_symbol", 32'(bits), 32'(IDLE));
                            idle_cnt++;
                        end else begin
                            nonempty = (exp_q.size() != 0);
                            check("symbol_expected", 32'(nonempty), 32'd1);
                            if (nonempty) check("data_symbol", 32'(bits), 32'(exp_q.pop_front()));
                            data_cnt++;
                        end
                        started = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int a0, a1, a2, base, snap;
        logic [9:0] seq;
        int k;
        reset = 1'b1;
        symbol_valid_i = 1'b0;
        symbol_i = 10'd0;
        m_valid_i = 1'b0;
        m_symbol_i = 10'd0;
        step();
        step();
        reset = 1'b0;

        // Reset state.
        check("rst_serial", 32'(serial_o), 32'd0);
        check("rst_start", 32'(symbol_start_o), 32'd1);
        check("rst_idle", 32'(idle_fill_o), 32'd1);
        check("rst_ready", 32'(symbol_ready_o), 32'd1);

        // 30 cycles of nothing: three fill symbols.
        repeat (30) step();
        check("idle_count", 32'(idle_cnt), 32'd3);

        // Single symbol offered mid-period lands in the hold register.
        wait_cnt(3);
        check("mid_ready", 32'(symbol_ready_o), 32'd1);
        symbol_i = 10'h2AA;
        symbol_valid_i = 1'b1;
        exp_q.push_back(10'h2AA);
        step();
        symbol_valid_i = 1'b0;
        check("hold_full_not_ready", 32'(symbol_ready_o), 32'd0);
        wait_cnt(0);
        check("single_start", 32'(symbol_start_o), 32'd1);
        check("single_not_idle", 32'(idle_fill_o), 32'd0);
        check("single_bit0", 32'(serial_o), 32'd0);
        wait_cnt(0);
        check("idle_resumes", 32'(idle_fill_o), 32'd1);
        check("single_done", 32'(data_cnt), 32'd1);

        // Back-to-back stream with valid held high.
        wait_cnt(5);
        base = data_cnt;
        send(10'h155, a0);
        send(10'h3F0, a1);
        send(10'h00F, a2);
        check("accept_gap_1", 32'(a1 - a0), 32'd4);
        check("accept_gap_2", 32'(a2 - a1), 32'd10);
        wait_data(base + 1);
        snap = idle_cnt;
        wait_data(base + 3);
        check("stream_no_idle", 32'(idle_cnt), 32'(snap));

        // Bypass: transfer at the boundary with the hold empty.
        wait_cnt(9);
        check("bypass_ready", 32'(symbol_ready_o), 32'd1);
        symbol_i = 10'h3A5;
        symbol_valid_i = 1'b1;
        exp_q.push_back(10'h3A5);
        step();
        symbol_valid_i = 1'b0;
        check("bypass_bit0", 32'(serial_o), 32'd1);
        check("bypass_start", 32'(symbol_start_o), 32'd1);
        check("bypass_not_idle", 32'(idle_fill_o), 32'd0);
        check("bypass_hold_empty", 32'(symbol_ready_o), 32'd1);
        wait_cnt(0);

        // Reset mid-symbol with the hold full drops both symbols.
        wait_cnt(9);
        symbol_i = 10'h0F0;
        symbol_valid_i = 1'b1;
        exp_q.push_back(10'h0F0);
        step();
        symbol_valid_i = 1'b0;
        wait_cnt(2);
        symbol_i = 10'h30C;
        symbol_valid_i = 1'b1;
        exp_q.push_back(10'h30C);
        step();
        symbol_valid_i = 1'b0;
        wait_cnt(5);
        check("pre_reset_hold_full", 32'(symbol_ready_o), 32'd0);
        snap = data_cnt;
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        check("mrst_serial", 32'(serial_o), 32'd0);
        check("mrst_start", 32'(symbol_start_o), 32'd1);
        check("mrst_idle", 32'(idle_fill_o), 32'd1);
        check("mrst_ready", 32'(symbol_ready_o), 32'd1);
        repeat (20) step();
        check("mrst_dropped", 32'(data_cnt), 32'(snap));

        // MSB-first instance: 10'h001 sends nine zeros then a one.
        m_symbol_i = 10'h001;
        m_valid_i = 1'b1;
        check("msb_ready", 32'(m_ready_o), 32'd1);
        step();
        m_valid_i = 1'b0;
        k = 0;
        while (!(m_start_o && !m_idle_o) && k < 20) begin
            step();
            k++;
        end
        check("msb_start_seen", 32'(k < 20), 32'd1);
        seq = 10'd0;
        for (int i = 0; i < 10; i++) begin
            seq[i] = m_serial_o;
            step();
        end
        check("msb_order", 32'(seq), 32'h200);
        check("msb_idle_after", 32'(m_idle_o), 32'd1);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_tx_serializer_10b
